hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 4, SHALL set the register index width.
REQ-002 Parameter NUM_REGS, default 16, SHALL equal 2**REG_W and SHALL set the number of tracked registers.
REQ-003 Parameter DEPTH, default 2, range 1..7, SHALL set the cycles a non-forwarded write stays pending.
REQ-004 Parameter FWD_EN, default 0, SHALL select forwarding mode when 1.
REQ-005 Parameter LOAD_LAT, default 1, range 1..DEPTH, SHALL set the cycles a load stays pending in forwarding mode.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 Port issue_valid, input, 1 bit: an instruction is present in ID this cycle.
REQ-009 Port src1, input, REG_W bits: first source register index.
REQ-010 Port src2, input, REG_W bits: second source register index.
REQ-011 Port has_two_src, input, 1 bit: src2 is used by the instruction.
REQ-012 Port dest, input, REG_W bits: destination register index.
REQ-013 Port wb_en, input, 1 bit: the instruction writes dest.
REQ-014 Port is_load, input, 1 bit: the instruction is a memory load.
REQ-015 Port ignore_hazard, input, 1 bit: suppresses hazard detection for this instruction.
REQ-016 Port flush, input, 1 bit: the instruction in ID is squashed this cycle.
REQ-017 Port hazard_detected, output, 1 bit: stall ID/IF this cycle.
REQ-018 Port pending_mask, output, NUM_REGS bits: bit r is 1 while register r has a nonzero counter.
REQ-019 Port busy, output, 1 bit: OR of pending_mask.
REQ-020 Port stall_count, output, 16 bits: saturating count of cycles with hazard_detected=1.

Function
REQ-021 The block SHALL hold one counter per register, each $clog2(DEPTH+1) bits wide; cnt[r]!=0 SHALL mean register r is pending.
REQ-022 hazard_detected SHALL be combinational and equal issue_valid & ~ignore_hazard & ~flush & (cnt[src1]!=0 | (has_two_src & cnt[src2]!=0)).
REQ-023 Hazard evaluation SHALL use the counter values registered before the current edge; the current instruction's own dest SHALL never cause its own hazard.
REQ-024 An issue event SHALL occur when issue_valid & wb_en & ~hazard_detected & ~flush are all 1.
REQ-025 On an issue event with FWD_EN=0, cnt[dest] SHALL load DEPTH at the next edge.
REQ-026 On an issue event with FWD_EN=1, cnt[dest] SHALL load LOAD_LAT if is_load=1; otherwise cnt[dest] SHALL be unchanged by the issue and only decrements.
REQ-027 Every nonzero counter not being loaded SHALL decrement by 1 per cycle; a zero counter SHALL remain at 0 and SHALL never wrap.
REQ-028 If a load and a decrement target the same register on the same edge, the load SHALL win.
REQ-029 A stalled instruction (hazard_detected=1) SHALL not be recorded; it SHALL be re-evaluated each cycle until the hazard clears.
REQ-030 ignore_hazard=1 SHALL suppress only detection; an instruction with ignore_hazard=1 and wb_en=1 SHALL still be recorded.
REQ-031 flush SHALL cancel only the current ID instruction; counters of instructions already issued SHALL continue to decrement unaffected.
REQ-032 stall_count SHALL increment by 1 on each cycle with hazard_detected=1 and SHALL saturate at 16'hFFFF.
REQ-033 pending_mask and busy SHALL be registered-state derived and SHALL have no combinational path from inputs.

Reset
REQ-034 While rst=1 at an edge, all counters SHALL be cleared to 0 and stall_count SHALL be cleared to 0.
REQ-035 After reset, pending_mask SHALL be 0, busy SHALL be 0, and hazard_detected SHALL be 0 for any inputs.
REQ-036 Reset asserted mid-operation SHALL discard all pending entries, and an issue presented in the same cycle SHALL not be recorded.

Verification
REQ-037 Scenario (FWD_EN=0, DEPTH=2): issue wb_en dest=3, then src1=3 on each of the next 3 cycles -> hazard_detected is 1,1,0, and stall_count=2.
REQ-038 Scenario (FWD_EN=0): issue dest=5, then has_two_src=0 with src2=5 -> hazard_detected=0; with has_two_src=1 -> hazard_detected=1.
REQ-039 Scenario (FWD_EN=1, LOAD_LAT=1): a non-load with dest=7 followed by src1=7 -> hazard_detected=0; a load with dest=7 followed by src1=7 -> exactly one stall cycle.
REQ-040 Scenario: issue dest=2 with flush=1, then src1=2 -> hazard_detected=0 and pending_mask[2]=0.
REQ-041 Scenario: dest=4 pending at cnt=1 while a new issue to dest=4 occurs -> cnt[4]=DEPTH next cycle and pending_mask[4] stays 1 throughout.
REQ-042 Scenario: force 70000 consecutive stalls -> stall_count holds 16'hFFFF; then assert rst -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register-pending scoreboard that raises ID-stage stalls on RAW hazards
//
// Purpose:
//   Tracks one down-counter per architectural register. A nonzero counter
//   means that register still has a write in flight. An instruction in ID
//   stalls while any register it reads is pending.
//
// Ports:
//   clk             - clock; all state updates on the rising edge
//   rst             - synchronous active-high reset
//   issue_valid     - an instruction is present in ID
//   src1, src2      - source register indices (src2 only when has_two_src)
//   has_two_src     - src2 is read by the instruction
//   dest, wb_en     - destination index and its write enable
//   is_load         - instruction is a memory load
//   ignore_hazard   - skip detection for this instruction; it is still recorded
//   flush           - squash the instruction in ID this cycle
//   hazard_detected - combinational stall request for ID/IF
//   pending_mask    - per-register pending flags, straight from state
//   busy            - any register pending
//   stall_count     - saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int NUM_REGS = 16,
  parameter int DEPTH    = 2,
  parameter int FWD_EN   = 0,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                has_two_src,
  input  logic [REG_W-1:0]    dest,
  input  logic                wb_en,
  input  logic                is_load,
  input  logic                ignore_hazard,
  input  logic                flush,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                busy,
  output logic [15:0]         stall_count
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam bit            FWD     = (FWD_EN != 0);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LOAD_C  = CW'(LOAD_LAT);

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic [15:0]   stall_q;
  logic [15:0]   stall_d;

  logic          issue;
  logic          load_en;
  logic [CW-1:0] load_val;

  // Pending flags come only from registered counters, so busy and the mask
  // never see a combinational path from the inputs.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    assign pending_mask[r] = (cnt_q[r] != '0);
  end

  assign busy        = |pending_mask;
  assign stall_count = stall_q;

  // Detection uses pre-edge state, so an instruction's own dest can never
  // stall itself.
  assign hazard_detected = issue_valid & ~ignore_hazard & ~flush &
                           (pending_mask[src1] | (has_two_src & pending_mask[src2]));

  assign issue = issue_valid & wb_en & ~hazard_detected & ~flush;

  // With forwarding, only loads leave a gap the bypass network cannot cover.
  assign load_en  = issue & (~FWD | is_load);
  assign load_val = FWD ? LOAD_C : DEPTH_C;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
      // A fresh issue to the same register overrides the decrement.
      if (load_en && (dest == REG_W'(r))) begin
        cnt_d[r] = load_val;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard_detected && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       has_two_src;
  logic [3:0] dest;
  logic       wb_en;
  logic       is_load;
  logic       ignore_hazard;
  logic       flush;

  logic        haz0, busy0, haz1, busy1, haz2, busy2;
  logic [15:0] mask0, mask1, mask2;
  logic [15:0] sc0, sc1, sc2;

  int n_cmp  = 0;
  int n_fail = 0;

  // u0: no forwarding, DEPTH=2; u1: forwarding, LOAD_LAT=1; u2: DEPTH=7 for saturation
  hazard_scoreboard #(.REG_W(4), .NUM_REGS(16), .DEPTH(2), .FWD_EN(0), .LOAD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
    .has_two_src(has_two_src), .dest(dest), .wb_en(wb_en), .is_load(is_load),
    .ignore_hazard(ignore_hazard), .flush(flush), .hazard_detected(haz0),
    .pending_mask(mask0), .busy(busy0), .stall_count(sc0));

  hazard_scoreboard #(.REG_W(4), .NUM_REGS(16), .DEPTH(2), .FWD_EN(1), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
    .has_two_src(has_two_src), .dest(dest), .wb_en(wb_en), .is_load(is_load),
    .ignore_hazard(ignore_hazard), .flush(flush), .hazard_detected(haz1),
    .pending_mask(mask1), .busy(busy1), .stall_count(sc1));

  hazard_scoreboard #(.REG_W(4), .NUM_REGS(16), .DEPTH(7), .FWD_EN(0), .LOAD_LAT(1)) u2 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
    .has_two_src(has_two_src), .dest(dest), .wb_en(wb_en), .is_load(is_load),
    .ignore_hazard(ignore_hazard), .flush(flush), .hazard_detected(haz2),
    .pending_mask(mask2), .busy(busy2), .stall_count(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        two;
    logic [3:0]  dst;
    logic        wb;
    logic        ld;
    logic        ign;
    logic        fl;
    logic        ehaz;
    logic [15:0] emask;
    logic [15:0] esc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic iv, logic [3:0] s1, logic [3:0] s2, logic two,
                             logic [3:0] dst, logic wb, logic ld, logic ign, logic fl,
                             logic ehaz, logic [15:0] emask, logic [15:0] esc);
    vec_t t;
    t.rst = r;  t.iv = iv;  t.s1 = s1;   t.s2 = s2;   t.two = two;
    t.dst = dst; t.wb = wb; t.ld = ld;   t.ign = ign; t.fl = fl;
    t.ehaz = ehaz; t.emask = emask; t.esc = esc;
    return t;
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are sampled 1 unit later.
  task automatic apply(logic r, logic iv, logic [3:0] s1, logic [3:0] s2, logic two,
                       logic [3:0] dst, logic wb, logic ld, logic ign, logic fl);
    @(negedge clk);
    rst = r; issue_valid = iv; src1 = s1; src2 = s2; has_two_src = two;
    dest = dst; wb_en = wb; is_load = ld; ignore_hazard = ign; flush = fl;
    #1;
  endtask

  task automatic idle_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int exp_sc;

  initial begin
    rst = 1'b1; issue_valid = 0; src1 = 0; src2 = 0; has_two_src = 0;
    dest = 0; wb_en = 0; is_load = 0; ignore_hazard = 0; flush = 0;

    //        rst iv s1 s2 two dst wb ld ign fl  haz mask      sc
    tbl.push_back(v(0, 1, 3, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0)); // after reset, any inputs
    tbl.push_back(v(0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0000, 0)); // issue dest=3
    tbl.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0));
    tbl.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 1));
    tbl.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 2));
    tbl.push_back(v(0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0000, 2)); // issue dest=5
    tbl.push_back(v(0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 2)); // src2 unused
    tbl.push_back(v(0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 16'h0020, 2)); // src2 used
    tbl.push_back(v(0, 1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 16'h0000, 3)); // flushed issue dest=2
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
    tbl.push_back(v(0, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 16'h0000, 3)); // issue dest=4
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0010, 3));
    tbl.push_back(v(0, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 16'h0010, 3)); // re-issue at cnt=1
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0010, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0010, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3));
    tbl.push_back(v(0, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 16'h0000, 3)); // issue dest=6
    tbl.push_back(v(0, 1, 6, 0, 0, 8, 1, 0, 1, 0, 0, 16'h0040, 3)); // ignore_hazard, recorded
    tbl.push_back(v(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0140, 3));
    tbl.push_back(v(0, 1, 8, 0, 0, 9, 1, 0, 0, 0, 1, 16'h0100, 4)); // stalled, not recorded
    tbl.push_back(v(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 5));
    tbl.push_back(v(0, 1,10, 0, 0,10, 1, 0, 0, 0, 0, 16'h0000, 5)); // own dest no self-stall
    tbl.push_back(v(0, 1,10, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0400, 5)); // flush masks hazard
    tbl.push_back(v(0, 0,10, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0400, 5)); // counter keeps running
    tbl.push_back(v(0, 1, 0, 0, 0,11, 1, 0, 0, 0, 0, 16'h0000, 5)); // issue dest=11
    tbl.push_back(v(1, 1, 0, 0, 0,12, 1, 0, 0, 0, 0, 16'h0800, 5)); // reset with issue
    tbl.push_back(v(0, 1,12,11, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0));

    idle_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].iv, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].dst,
            tbl[i].wb, tbl[i].ld, tbl[i].ign, tbl[i].fl);
      check($sformatf("row%0d hazard", i), 16'(haz0), 16'(tbl[i].ehaz));
      check($sformatf("row%0d mask", i), mask0, tbl[i].emask);
      check($sformatf("row%0d busy", i), 16'(busy0), 16'(tbl[i].emask != 16'h0));
      check($sformatf("row%0d stall_count", i), sc0, tbl[i].esc);
    end

    // Forwarding: non-load never stalls a consumer; a load stalls exactly once.
    idle_reset();
    apply(0, 1, 0, 0, 0, 7, 1, 0, 0, 0);
    check("fwd alu issue hazard", 16'(haz1), 16'd0);
    apply(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check("fwd alu use hazard", 16'(haz1), 16'd0);
    check("fwd alu use mask", mask1, 16'h0000);
    apply(0, 1, 0, 0, 0, 7, 1, 1, 0, 0);
    check("fwd load issue hazard", 16'(haz1), 16'd0);
    apply(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check("fwd load use hazard1", 16'(haz1), 16'd1);
    check("fwd load use mask", mask1, 16'h0080);
    apply(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check("fwd load use hazard2", 16'(haz1), 16'd0);
    check("fwd load use mask2", mask1, 16'h0000);
    check("fwd stall_count", sc1, 16'd1);

    // Saturation on the DEPTH=7 instance: each issue is followed by 7 stalls.
    idle_reset();
    exp_sc = 0;
    for (int it = 0; it < 9372; it++) begin
      apply(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
      if (it % 1000 == 0) check($sformatf("sat it%0d stall_count", it), sc2, 16'(exp_sc));
      for (int k = 0; k < 7; k++) begin
        apply(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        if (k == 6) check($sformatf("sat it%0d last hazard", it), 16'(haz2), 16'd1);
        if (exp_sc < 65535) exp_sc++;
      end
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat final stall_count", sc2, 16'hFFFF);
    apply(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    apply(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    check("post-rst hazard", 16'(haz2), 16'd0);
    check("post-rst mask", mask2, 16'h0000);
    check("post-rst busy", 16'(busy2), 16'd0);
    check("post-rst stall_count", sc2, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
